// File: rtl/opb_register_simulink2ppc_snap_if.sv
// OPB bus bundle between the PowerPC-side master and the snapshot register slave.
// Big-endian OPB bit numbering: index 0 is the most significant bit.
interface opb_register_simulink2ppc_snap_if;
   logic [0:31] OPB_ABus;
   logic [0:3]  OPB_BE;
   logic [0:31] OPB_DBus;
   logic        OPB_RNW;
   logic        OPB_select;
   logic        OPB_seqAddr;
   logic [0:31] Sl_DBus;
   logic        Sl_xferAck;
   logic        Sl_errAck;
   logic        Sl_retry;
   logic        Sl_toutSup;

   modport master (
      output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );

   modport slave (
      input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );
endinterface

// File: rtl/opb_register_simulink2ppc_snap.sv
// Fabric-to-PowerPC snapshot register: captures a user word on a strobe and exposes
// DATA / STATUS (new_data, overrun, freeze, update count) / CTRL over a 256-byte OPB window.
module opb_register_simulink2ppc_snap #(
   parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
   parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter string       C_FAMILY     = "virtex5"
) (
   input  logic                                   OPB_Clk,
   input  logic                                   OPB_Rst_n,
   opb_register_simulink2ppc_snap_if.slave        opb,
   input  logic [31:0]                            user_data_in,
   input  logic                                   user_we,
   output logic                                   user_overrun
);

   localparam logic [5:0] LP_OFF_DATA   = 6'd0;
   localparam logic [5:0] LP_OFF_STATUS = 6'd1;
   localparam logic [5:0] LP_OFF_CTRL   = 6'd2;

   logic [31:0]             r_data;
   logic                    r_newData;
   logic                    r_overrun;
   logic                    r_freeze;
   logic [15:0]             r_count;
   logic                    r_xferAck;
   logic [C_OPB_DWIDTH-1:0] r_rdData;

   logic [C_OPB_AWIDTH-1:0] w_addr;
   logic [31:0]             w_relAddr;
   logic                    w_hit;
   logic [5:0]              w_offset;
   logic                    w_start;
   logic                    w_rd;
   logic                    w_wr;
   logic                    w_capture;
   logic                    w_dataRdAck;
   logic                    w_ctrlWr;
   logic                    w_clr;
   logic [31:0]             w_status;
   logic [31:0]             w_rdMux;
   logic                    w_unused;

   // Subtract-then-compare keeps the window test free of constant comparisons when the base is zero.
   assign w_addr      = opb.OPB_ABus;
   assign w_relAddr   = w_addr - C_BASEADDR;
   assign w_hit       = (w_relAddr <= (C_HIGHADDR - C_BASEADDR));
   assign w_offset    = opb.OPB_ABus[24:29];

   assign w_start     = opb.OPB_select & w_hit & ~r_xferAck;
   assign w_rd        = w_start & opb.OPB_RNW;
   assign w_wr        = w_start & ~opb.OPB_RNW;
   assign w_capture   = user_we & ~r_freeze;
   assign w_dataRdAck = w_rd & (w_offset == LP_OFF_DATA);
   assign w_ctrlWr    = w_wr & (w_offset == LP_OFF_CTRL) & opb.OPB_BE[3];
   assign w_clr       = w_ctrlWr & opb.OPB_DBus[30];

   assign w_status    = {r_count, 13'b0, r_freeze, r_overrun, r_newData};

   always_comb begin
      w_rdMux = 32'h0;
      case (w_offset)
         LP_OFF_DATA:   w_rdMux = r_data;
         LP_OFF_STATUS: w_rdMux = w_status;
         LP_OFF_CTRL:   w_rdMux = {31'b0, r_freeze};
         default:       w_rdMux = 32'h0;
      endcase
   end

   // A capture in the ack cycle wins over the new_data clear; clr wipes the old state before this capture lands.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         r_data    <= 32'h0;
         r_newData <= 1'b0;
         r_overrun <= 1'b0;
         r_freeze  <= 1'b0;
         r_count   <= 16'h0;
         r_xferAck <= 1'b0;
         r_rdData  <= '0;
      end else begin
         r_xferAck <= w_start;
         r_rdData  <= w_rd ? w_rdMux : '0;

         if (w_capture) begin
            r_data <= user_data_in;
         end

         if (w_capture) begin
            r_newData <= 1'b1;
         end else if (w_dataRdAck) begin
            r_newData <= 1'b0;
         end

         r_overrun <= (r_overrun & ~w_clr) | (w_capture & r_newData);
         r_count   <= (w_clr ? 16'h0 : r_count) + {15'b0, w_capture};

         if (w_ctrlWr) begin
            r_freeze <= opb.OPB_DBus[31];
         end
      end
   end

   assign opb.Sl_DBus    = r_rdData;
   assign opb.Sl_xferAck = r_xferAck;
   assign opb.Sl_errAck  = 1'b0;
   assign opb.Sl_retry   = 1'b0;
   assign opb.Sl_toutSup = 1'b0;
   assign user_overrun   = r_overrun;

   assign w_unused = &{1'b0, opb.OPB_BE[0:2], opb.OPB_DBus[0:29], opb.OPB_seqAddr};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Scoreboard bench for the snapshot register: reads push expected words, the ack monitor pops and compares.
module tb_opb_register_simulink2ppc_snap;

   logic        clock;
   logic        rstN;
   logic [31:0] userDataIn;
   logic        userWe;
   logic        userOverrun;
   int          testsRun;
   int          testsFailed;
   logic [31:0] expQ[$];
   string       tagQ[$];

   opb_register_simulink2ppc_snap_if bus();

   opb_register_simulink2ppc_snap dut (
      .OPB_Clk      (clock),
      .OPB_Rst_n    (rstN),
      .opb          (bus.slave),
      .user_data_in (userDataIn),
      .user_we      (userWe),
      .user_overrun (userOverrun)
   );

   // Free-running 10-unit clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Scoreboard consumer: every read ack pops the word queued when the read was issued
   always @(negedge clock) begin
      if (bus.Sl_xferAck === 1'b1 && expQ.size() > 0) begin
         checkOutput(tagQ.pop_front(), bus.Sl_DBus, expQ.pop_front());
      end
   end

   // Drives one OPB transfer, optionally with a simultaneous user capture, and checks ack timing
   task automatic applyStimulus(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [31:0] expected, input string tag,
                                input logic withCapture, input logic [31:0] capData);
      int waitCycles;
      bit gotAck;
      @(negedge clock);
      bus.OPB_ABus   = addr;
      bus.OPB_DBus   = wdata;
      bus.OPB_BE     = be;
      bus.OPB_RNW    = rnw;
      bus.OPB_select = 1'b1;
      if (withCapture) begin
         userWe     = 1'b1;
         userDataIn = capData;
      end
      if (rnw) begin
         expQ.push_back(expected);
         tagQ.push_back(tag);
      end
      waitCycles = 0;
      gotAck     = 1'b0;
      while (!gotAck && waitCycles < 8) begin
         @(negedge clock);
         waitCycles++;
         userWe = 1'b0;
         if (bus.Sl_xferAck === 1'b1) gotAck = 1'b1;
      end
      bus.OPB_select = 1'b0;
      if (!gotAck) begin
         checkOutput({tag, "_ackTimeout"}, 32'd0, 32'd1);
         if (rnw && expQ.size() > 0) begin
            void'(expQ.pop_back());
            void'(tagQ.pop_back());
         end
      end else begin
         checkOutput({tag, "_ackLatency"}, waitCycles, 32'd1);
         @(negedge clock);
         checkOutput({tag, "_ackWidth"}, {31'b0, bus.Sl_xferAck}, 32'd0);
      end
   endtask

   task automatic opbRead(input logic [31:0] addr, input logic [31:0] expected, input string tag);
      applyStimulus(1'b1, addr, 32'h0, 4'hF, expected, tag, 1'b0, 32'h0);
   endtask

   task automatic opbWrite(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be, input string tag);
      applyStimulus(1'b0, addr, wdata, be, 32'h0, tag, 1'b0, 32'h0);
   endtask

   task automatic pulseWe(input logic [31:0] value);
      @(negedge clock);
      userWe     = 1'b1;
      userDataIn = value;
      @(negedge clock);
      userWe     = 1'b0;
   endtask

   // Main sequence
   initial begin
      testsRun       = 0;
      testsFailed    = 0;
      rstN           = 1'b0;
      userWe         = 1'b0;
      userDataIn     = 32'h0;
      bus.OPB_ABus   = 32'h0;
      bus.OPB_BE     = 4'h0;
      bus.OPB_DBus   = 32'h0;
      bus.OPB_RNW    = 1'b0;
      bus.OPB_select = 1'b0;
      bus.OPB_seqAddr = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("rst_dbus", bus.Sl_DBus, 32'h0);
      checkOutput("rst_ack", {31'b0, bus.Sl_xferAck}, 32'h0);
      checkOutput("rst_overrun", {31'b0, userOverrun}, 32'h0);
      rstN = 1'b1;

      opbRead(32'h00, 32'h0, "rst_data");
      opbRead(32'h04, 32'h0, "rst_status");
      opbRead(32'h08, 32'h0, "rst_ctrl");

      pulseWe(32'hDEADBEEF);
      opbRead(32'h04, 32'h0001_0001, "cap_status");
      opbRead(32'h00, 32'hDEADBEEF, "cap_data");
      opbRead(32'h04, 32'h0001_0000, "cap_status_clr");

      opbWrite(32'h08, 32'h2, 4'b0001, "clr0");
      pulseWe(32'h1);
      pulseWe(32'h2);
      opbRead(32'h04, 32'h0002_0003, "ovr_status");
      checkOutput("ovr_pin", {31'b0, userOverrun}, 32'h1);
      opbWrite(32'h08, 32'h2, 4'b0001, "clr1");
      opbRead(32'h04, 32'h0000_0001, "clr_status");
      checkOutput("clr_pin", {31'b0, userOverrun}, 32'h0);

      opbWrite(32'h08, 32'h1, 4'hF, "frz_set");
      pulseWe(32'h55);
      opbRead(32'h00, 32'h2, "frz_data");
      opbRead(32'h04, 32'h0000_0004, "frz_status");
      opbWrite(32'h08, 32'h0, 4'b1110, "frz_be");
      opbRead(32'h08, 32'h1, "frz_ctrl_kept");
      opbWrite(32'h08, 32'h0, 4'hF, "frz_off");
      opbRead(32'h08, 32'h0, "frz_ctrl_off");

      applyStimulus(1'b1, 32'h00, 32'h0, 4'hF, 32'h2, "sim_rd_old", 1'b1, 32'hA5A5A5A5);
      opbRead(32'h04, 32'h0001_0001, "sim_status");
      opbRead(32'h00, 32'hA5A5A5A5, "sim_data");

      pulseWe(32'h11);
      applyStimulus(1'b0, 32'h08, 32'h2, 4'b0001, 32'h0, "sim_clr", 1'b1, 32'h22);
      opbRead(32'h04, 32'h0001_0003, "sim_clr_status");

      opbWrite(32'h08, 32'h2, 4'b0001, "clr2");
      for (int i = 0; i < 65535; i++) begin
         @(negedge clock);
         userWe     = 1'b1;
         userDataIn = i;
      end
      @(negedge clock);
      userWe = 1'b0;
      opbRead(32'h04, 32'hFFFF_0003, "wrap_full");
      opbRead(32'h00, 32'h0000_FFFE, "wrap_data");
      pulseWe(32'h77);
      opbRead(32'h04, 32'h0000_0003, "wrap_zero");

      opbWrite(32'h0C, 32'hFFFF_FFFF, 4'hF, "unmap_wr");
      opbRead(32'h0C, 32'h0, "unmap_rd");
      opbRead(32'hFC, 32'h0, "unmap_top");
      opbWrite(32'h04, 32'h0, 4'hF, "status_wr");
      opbRead(32'h00, 32'h77, "ro_data");

      // An address outside the window must never be acknowledged
      begin
         bit sawAck;
         sawAck = 1'b0;
         @(negedge clock);
         bus.OPB_ABus   = 32'h100;
         bus.OPB_RNW    = 1'b1;
         bus.OPB_select = 1'b1;
         repeat (4) begin
            @(negedge clock);
            if (bus.Sl_xferAck === 1'b1) sawAck = 1'b1;
         end
         bus.OPB_select = 1'b0;
         checkOutput("miss_noack", {31'b0, sawAck}, 32'h0);
      end

      // Reset pulse while a read is pending: outputs clear at once, no ack follows
      begin
         bit sawAck;
         sawAck = 1'b0;
         @(negedge clock);
         bus.OPB_ABus   = 32'h04;
         bus.OPB_RNW    = 1'b1;
         bus.OPB_select = 1'b1;
         rstN           = 1'b0;
         #1;
         checkOutput("arst_pin", {31'b0, userOverrun}, 32'h0);
         checkOutput("arst_dbus", bus.Sl_DBus, 32'h0);
         checkOutput("arst_ack", {31'b0, bus.Sl_xferAck}, 32'h0);
         @(negedge clock);
         rstN           = 1'b1;
         bus.OPB_select = 1'b0;
         repeat (2) begin
            @(negedge clock);
            if (bus.Sl_xferAck === 1'b1) sawAck = 1'b1;
         end
         checkOutput("arst_noack", {31'b0, sawAck}, 32'h0);
      end
      opbRead(32'h04, 32'h0, "arst_status");
      opbRead(32'h00, 32'h0, "arst_data");

      repeat (2) @(negedge clock);
      checkOutput("sb_drained", expQ.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
